gpio_out_arbiter: RTL and testbench
===================================

GPIO_OUT_ARBITER -- requirements
Module: gpio_out_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, range 0-255: idle cycles enforced after each write before the next grant.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CLR  input  1  synchronous clear of the output register, active-high.
REQ-005 REQ  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 WR_DATA  input  32  packed byte data; requester i uses bits [8i+7:8i].
REQ-007 WR_LANE  input  8  packed byte-lane select; requester i uses bits [2i+1:2i], where lane k maps to GPIO_OUT[8k+7:8k].
REQ-008 ACK  output  4  one-hot write acknowledge; all bits zero except during a WRITE cycle.
REQ-009 GPIO_OUT  output  32  registered header output value.
REQ-010 BUSY  output  1  high whenever the state is not IDLE.
REQ-011 OWNER  output  2  index of the last requester that completed a write.

Function
REQ-012 The FSM SHALL have three states: IDLE, WRITE and HOLD.
REQ-013 IDLE: the arbiter SHALL move to WRITE if any REQ bit is high and CLR is low, and SHALL latch the winner; otherwise it stays in IDLE.
REQ-014 Winner selection SHALL be round-robin: the first high REQ bit, searching upward from pointer PTR and wrapping 3->0.
REQ-015 WRITE state lasts exactly one cycle; the actions depend on whether the winner's REQ is still high:
  - REQ high: ACK[winner] is asserted combinationally; GPIO_OUT byte lane WR_LANE[winner] loads WR_DATA[winner] at the closing edge; all other lanes hold their value.
  - REQ high: OWNER is set to winner and PTR to (winner+1) mod 4.
  - REQ low: the write is abandoned; no ACK, no GPIO_OUT change, PTR and OWNER unchanged; next state is IDLE.
REQ-016 After a completed write, the next state SHALL be HOLD with counter = HOLD_CYCLES-1, or IDLE if HOLD_CYCLES = 0.
REQ-017 HOLD: the counter decrements every cycle; when the counter is 0 the next state is IDLE. REQ is ignored in HOLD.
REQ-018 Timing: REQ sampled high in IDLE at edge n gives WRITE and ACK during cycle n..n+1. The new GPIO_OUT value is visible after edge n+1. Back-to-back grants are spaced HOLD_CYCLES+2 cycles apart.
REQ-019 Requesters SHALL hold REQ, WR_DATA and WR_LANE stable until ACK; data is sampled only in the WRITE cycle.
REQ-020 CLR high at any edge SHALL zero GPIO_OUT and take priority over any lane write:
  - CLR in WRITE suppresses ACK and goes to IDLE with PTR unchanged.
  - CLR in HOLD does not alter the counter.
  - CLR in IDLE blocks the grant.
REQ-021 RESET asserted mid-operation SHALL abort immediately; any in-progress ACK is dropped combinationally.
REQ-022 The counter SHALL be 8 bits and SHALL never underflow.

Reset
REQ-023 While RESET is high, regardless of the clock: GPIO_OUT = 0, state = IDLE, ACK = 0, BUSY = 0, OWNER = 0, PTR = 0, counter = 0.
REQ-024 Operation SHALL resume on the first rising edge after RESET is released.

Verification
REQ-025 Reset, then REQ=0001, WR_LANE[1:0]=2, WR_DATA[7:0]=A5 -> ACK=0001 for one cycle; GPIO_OUT=00A50000; OWNER=0; BUSY high for 1+4 cycles.
REQ-026 REQ=1111 held, each requester targeting its own lane with data 11,22,33,44 -> ACK order 0,1,2,3,0 at a 6-cycle pitch; GPIO_OUT=44332211 after four writes.
REQ-027 PTR=2 and REQ=0011 -> requester 0 granted first, then requester 1.
REQ-028 Overlap and lane isolation:
  - CLR asserted during the WRITE cycle of a lane-0 write of FF -> no ACK; GPIO_OUT=0; next grant goes to the same requester.
  - A lane-3 write of 80 -> GPIO_OUT[31:24]=80 with the other bytes unchanged.
REQ-029 Requester drops REQ in the WRITE cycle -> no ACK; GPIO_OUT unchanged; back to IDLE on the next cycle.
REQ-030 HOLD_CYCLES=0 with REQ=0011 held -> grants every 2 cycles; RESET pulsed mid-HOLD -> all outputs zero asynchronously.

Source files
------------

// File: rtl/gpio_out_arbiter.sv
// Four-requester round-robin arbiter for byte-lane writes into a 32-bit GPIO output register.
// After each completed write, a hold window of HOLD_CYCLES idle cycles runs before the next grant.
module gpio_out_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clock_50_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] wr_data_i,
  input  logic [7:0]  wr_lane_i,
  output logic [3:0]  ack_o,
  output logic [31:0] gpio_out_o,
  output logic        busy_o,
  output logic [1:0]  owner_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] gpio_q, gpio_d;

  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       write_go;
  logic [7:0] win_data;
  logic [1:0] win_lane;

  // Round-robin search upward from the pointer, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign win_data = wr_data_i[{win_q, 3'b000} +: 8];
  assign win_lane = wr_lane_i[{win_q, 1'b0} +: 2];
  assign write_go = (state_q == S_WRITE) && req_i[win_q] && !clr_i;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gpio_d  = gpio_q;
    case (state_q)
      S_IDLE: begin
        if (found && !clr_i) begin
          state_d = S_WRITE;
          win_d   = pick;
        end
      end
      S_WRITE: begin
        if (write_go) begin
          gpio_d[{win_lane, 3'b000} +: 8] = win_data;
          owner_d = win_q;
          ptr_d   = win_q + 2'd1;
          if (HOLD_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear wins over any lane write landing on the same edge.
    if (clr_i) gpio_d = '0;
  end

  always_ff @(posedge clock_50_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
    end
  end

  assign ack_o      = (write_go && !reset_i) ? (4'b0001 << win_q) : 4'b0000;
  assign gpio_out_o = gpio_q;
  assign busy_o     = (state_q != S_IDLE);
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_gpio_out_arbiter.sv
// Directed bench for gpio_out_arbiter: a vector table for a single write, then hand-written
// sequences for round-robin order, clear/abandon/reset corners, and the zero-hold variant.
module tb_gpio_out_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clr = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_lane = '0;
  logic [3:0]  ack;
  logic [31:0] gpio;
  logic        busy;
  logic [1:0]  owner;

  logic        z_rst = 1'b1, z_clr = 1'b0;
  logic [3:0]  z_req = '0;
  logic [31:0] z_data = '0;
  logic [7:0]  z_lane = '0;
  logic [3:0]  z_ack;
  logic [31:0] z_gpio;
  logic        z_busy;
  logic [1:0]  z_owner;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_out_arbiter #(.HOLD_CYCLES(4)) dut (
    .clock_50_i(clk), .reset_i(rst), .clr_i(clr), .req_i(req),
    .wr_data_i(wr_data), .wr_lane_i(wr_lane), .ack_o(ack),
    .gpio_out_o(gpio), .busy_o(busy), .owner_o(owner)
  );

  gpio_out_arbiter #(.HOLD_CYCLES(0)) dut0 (
    .clock_50_i(clk), .reset_i(z_rst), .clr_i(z_clr), .req_i(z_req),
    .wr_data_i(z_data), .wr_lane_i(z_lane), .ack_o(z_ack),
    .gpio_out_o(z_gpio), .busy_o(z_busy), .owner_o(z_owner)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  lane;
    logic [31:0] data;
    logic        clr;
    logic [3:0]  exp_ack;
    logic [31:0] exp_gpio;
    logic        exp_busy;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; z_rst = 1'b1;
    clr = 1'b0; req = '0; wr_data = '0; wr_lane = '0;
    z_clr = 1'b0; z_req = '0; z_data = '0; z_lane = '0;
    @(negedge clk); #1;
    chk("reset ack", ack, 0);
    chk("reset gpio", gpio, 0);
    chk("reset busy", busy, 0);
    chk("reset owner", owner, 0);
    rst = 1'b0; z_rst = 1'b0;
  endtask

  task automatic wait_ack(input string name, input logic [3:0] exp);
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk); #1;
      if (ack != 4'b0000) seen = 1;
    end
    chk(name, ack, exp);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int k = 0; k < 30 && !idle; k++) begin
      @(negedge clk); #1;
      if (!busy) idle = 1;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    int gcnt, last, k;

    // req | lane | data | clr | ack | gpio | busy | owner
    vecs[0] = '{4'b0000, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00000000, 1'b0, 2'd0};
    vecs[1] = '{4'b0001, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00000000, 1'b0, 2'd0};
    vecs[2] = '{4'b0001, 8'h02, 32'h000000A5, 1'b0, 4'b0001, 32'h00000000, 1'b1, 2'd0};
    vecs[3] = '{4'b0000, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00A50000, 1'b1, 2'd0};
    vecs[4] = '{4'b0000, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00A50000, 1'b1, 2'd0};
    vecs[5] = '{4'b0000, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00A50000, 1'b1, 2'd0};
    vecs[6] = '{4'b0000, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00A50000, 1'b1, 2'd0};
    vecs[7] = '{4'b0000, 8'h02, 32'h000000A5, 1'b0, 4'b0000, 32'h00A50000, 1'b0, 2'd0};

    #2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = vecs[i].req; wr_lane = vecs[i].lane; wr_data = vecs[i].data; clr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d ack", i), ack, vecs[i].exp_ack);
      chk($sformatf("vec%0d gpio", i), gpio, vecs[i].exp_gpio);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d owner", i), owner, vecs[i].exp_owner);
    end

    // All four requesting, each into its own lane.
    do_reset();
    @(negedge clk);
    req = 4'hF; wr_lane = 8'hE4; wr_data = 32'h44332211;
    gcnt = 0; last = 0;
    for (int c = 0; c < 40 && gcnt < 5; c++) begin
      @(negedge clk); #1;
      if (ack != 4'b0000) begin
        if (gcnt == 4) chk("rr gpio after four", gpio, 32'h44332211);
        chk($sformatf("rr order %0d", gcnt), ack, 32'd1 << (gcnt % 4));
        if (gcnt > 0) chk("rr pitch", c - last, 6);
        last = c;
        gcnt++;
      end
    end
    chk("rr grant count", gcnt, 5);
    @(negedge clk); req = '0;
    wait_idle("rr idle");

    // Pointer at 2 after a requester-1 write; requester 0 wraps around first.
    do_reset();
    @(negedge clk); req = 4'b0010; wr_lane = 8'h00; wr_data = 32'h0;
    wait_ack("ptr setup", 4'b0010);
    @(negedge clk); req = '0;
    wait_idle("ptr setup idle");
    @(negedge clk); req = 4'b0011;
    wait_ack("ptr2 first", 4'b0001);
    wait_ack("ptr2 second", 4'b0010);
    @(negedge clk); #1;
    chk("ptr2 owner", owner, 1);
    req = '0;
    wait_idle("ptr2 idle");

    // Clear in the WRITE cycle, then lane isolation and clear during hold.
    do_reset();
    @(negedge clk); req = 4'b1000; wr_lane = 8'hC0; wr_data = 32'h80000000;
    wait_ack("pre lane3 ack", 4'b1000);
    @(negedge clk); req = '0; #1;
    chk("pre lane3 gpio", gpio, 32'h80000000);
    wait_idle("pre idle");
    @(negedge clk); req = 4'b0011; wr_lane = 8'h04; wr_data = 32'h000077FF;
    @(negedge clk); clr = 1'b1; #1;
    chk("clr write ack", ack, 0);
    @(negedge clk); clr = 1'b0; #1;
    chk("clr write busy", busy, 0);
    chk("clr write gpio", gpio, 0);
    wait_ack("clr retry ack", 4'b0001);
    @(negedge clk); req = '0; #1;
    chk("retry gpio", gpio, 32'h000000FF);
    chk("retry owner", owner, 0);
    wait_idle("retry idle");
    @(negedge clk); req = 4'b0100; wr_lane = 8'h30; wr_data = 32'h00800000;
    wait_ack("iso ack", 4'b0100);
    @(negedge clk); req = '0; #1;
    chk("iso gpio", gpio, 32'h800000FF);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0; #1;
    chk("hold clr gpio", gpio, 0);
    chk("hold clr busy", busy, 1);
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("hold clr remaining", k, 3);

    // Requester drops REQ in the WRITE cycle.
    @(negedge clk); req = 4'b0010; wr_lane = 8'h04; wr_data = 32'h00005500;
    @(negedge clk); req = '0; #1;
    chk("drop ack", ack, 0);
    chk("drop busy write", busy, 1);
    @(negedge clk); #1;
    chk("drop busy after", busy, 0);
    chk("drop gpio", gpio, 0);
    chk("drop owner", owner, 2);

    // Asynchronous reset mid-HOLD, then mid-WRITE.
    @(negedge clk); req = 4'b1000; wr_lane = 8'hC0; wr_data = 32'h3C000000;
    wait_ack("rst pre ack", 4'b1000);
    @(negedge clk); req = '0; #1;
    chk("rst pre gpio", gpio, 32'h3C000000);
    chk("rst pre owner", owner, 3);
    #2 rst = 1'b1; #1;
    chk("rst hold gpio", gpio, 0);
    chk("rst hold busy", busy, 0);
    chk("rst hold owner", owner, 0);
    #1 rst = 1'b0;
    @(negedge clk); req = 4'b0001; wr_lane = 8'h00; wr_data = 32'h0000005A;
    @(negedge clk); #1;
    chk("rst write ack before", ack, 4'b0001);
    rst = 1'b1; #1;
    chk("rst write ack after", ack, 0);
    chk("rst write busy", busy, 0);
    rst = 1'b0; req = '0;

    // Zero hold: two requesters alternate every other cycle.
    do_reset();
    @(negedge clk); z_req = 4'b0011; z_lane = 8'h04; z_data = 32'h0000BBAA;
    gcnt = 0; last = 0;
    for (int c = 0; c < 20 && gcnt < 4; c++) begin
      @(negedge clk); #1;
      if (z_ack != 4'b0000) begin
        chk($sformatf("hold0 order %0d", gcnt), z_ack, 32'd1 << (gcnt % 2));
        if (gcnt > 0) chk("hold0 pitch", c - last, 2);
        last = c;
        gcnt++;
      end
    end
    chk("hold0 grant count", gcnt, 4);
    z_req = '0;
    @(negedge clk); #1;
    chk("hold0 gpio", z_gpio, 32'h0000BBAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
